escalonador_quantum: RTL and testbench

- Preemptive round-robin scheduler with instruction-quantum timer; sits directly upstream of the OS control block (controla_so).
- Drives the Set_pid_0 pulse (hand CPU to OS, PID 0), and the Set_ctx pulse with id_proc_atual (dispatch next user process).
- Counts retired user-process instructions, preempts on quantum expiry or process HALT, selects the next ready process among PIDs 1..3.

---
 rtl/escalonador_quantum_if.sv | 44 ++++
 rtl/escalonador_quantum.sv | 111 +++++++++++
 tb/tb_escalonador_quantum.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/escalonador_quantum_if.sv
// Bus between the quantum scheduler and the OS control block.
// The n_preempcoes statistic exists only with ESCALONADOR_ESTATISTICA_EN defined.
interface escalonador_quantum_if #(
  parameter int QW = 8
);
  logic          Sel_BIOS;
  logic [1:0]    id_proc;
  logic          instr_valida;
  logic          fim_proc;
  logic          ack_so;
  logic          quantum_wr;
  logic [QW-1:0] quantum_din;
  logic          pronto_wr;
  logic [3:0]    pronto_din;
  logic          Set_pid_0;
  logic          Set_ctx;
  logic [1:0]    id_proc_atual;
  logic [3:0]    pronto;
`ifdef ESCALONADOR_ESTATISTICA_EN
  logic [15:0]   n_preempcoes;

  modport slave (
    input  Sel_BIOS, id_proc, instr_valida, fim_proc, ack_so,
           quantum_wr, quantum_din, pronto_wr, pronto_din,
    output Set_pid_0, Set_ctx, id_proc_atual, pronto, n_preempcoes
  );
  modport master (
    output Sel_BIOS, id_proc, instr_valida, fim_proc, ack_so,
           quantum_wr, quantum_din, pronto_wr, pronto_din,
    input  Set_pid_0, Set_ctx, id_proc_atual, pronto, n_preempcoes
  );
`else
  modport slave (
    input  Sel_BIOS, id_proc, instr_valida, fim_proc, ack_so,
           quantum_wr, quantum_din, pronto_wr, pronto_din,
    output Set_pid_0, Set_ctx, id_proc_atual, pronto
  );
  modport master (
    output Sel_BIOS, id_proc, instr_valida, fim_proc, ack_so,
           quantum_wr, quantum_din, pronto_wr, pronto_din,
    input  Set_pid_0, Set_ctx, id_proc_atual, pronto
  );
`endif
endinterface

// File: rtl/escalonador_quantum.sv
// Preemptive round-robin scheduler (PIDs 1..3) with instruction-quantum timer.
// Optional ESCALONADOR_ESTATISTICA_EN adds a saturating quantum-expiry counter.
module escalonador_quantum #(
  parameter int            QW          = 8,
  parameter logic [QW-1:0] QUANTUM_INI = QW'(16)
) (
  input logic clk,
  input logic reset,
  escalonador_quantum_if.slave bus
);

  typedef enum logic [2:0] {
    OCIOSO, DESPACHA, EXECUTANDO, PREEMPTA, AGUARDA_SO
  } state_t;

  state_t        state;
  logic          set_pid_0_r, set_ctx_r;
  logic [1:0]    atual, last;
  logic [3:0]    pronto_r;
  logic [QW-1:0] quantum, q_ativo, cnt;
  logic [1:0]    nxt_pid;
  logic          found, count_en, expira;

  // Round-robin pick: candidates last+1, last+2, last+3 folded into 1..3;
  // iterate backwards so the nearest ready PID wins.
  always_comb begin
    nxt_pid = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      int cand;
      cand = ((int'(last) + k) % 3) + 1;
      if (pronto_r[cand]) nxt_pid = 2'(cand);
    end
  end

  assign found    = (nxt_pid != 2'd0);
  assign count_en = bus.instr_valida && (bus.id_proc != 2'd0);
  assign expira   = count_en && (q_ativo != '0) && (cnt == QW'(q_ativo - 1'b1));

  // Pulses are launched on the edge entering DESPACHA/PREEMPTA so each
  // appears one cycle after its cause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= OCIOSO;
      set_pid_0_r <= 1'b0;
      set_ctx_r   <= 1'b0;
      atual       <= 2'd0;
      last        <= 2'd3;
      pronto_r    <= 4'd0;
      cnt         <= '0;
      quantum     <= QUANTUM_INI;
      q_ativo     <= QUANTUM_INI;
    end else begin
      set_pid_0_r <= 1'b0;
      set_ctx_r   <= 1'b0;
      if (bus.quantum_wr) quantum  <= bus.quantum_din;
      if (bus.pronto_wr)  pronto_r <= bus.pronto_din & 4'b1110;
      if (bus.Sel_BIOS) begin
        state <= OCIOSO;
        cnt   <= '0;
      end else begin
        case (state)
          OCIOSO, AGUARDA_SO: begin
            if (bus.ack_so) begin
              state <= DESPACHA;
              if (found) begin
                set_ctx_r <= 1'b1;
                atual     <= nxt_pid;
                last      <= nxt_pid;
                cnt       <= '0;
                q_ativo   <= quantum;
              end
            end
          end
          DESPACHA: state <= set_ctx_r ? EXECUTANDO : OCIOSO;
          EXECUTANDO: begin
            if (count_en && cnt != '1) cnt <= cnt + 1'b1;
            // Later assignment overrides a same-cycle pronto_wr.
            if (bus.fim_proc) pronto_r[atual] <= 1'b0;
            if (expira || bus.fim_proc) begin
              state       <= PREEMPTA;
              set_pid_0_r <= 1'b1;
              cnt         <= '0;
            end
          end
          PREEMPTA: state <= AGUARDA_SO;
          default:  state <= OCIOSO;
        endcase
      end
    end
  end

  assign bus.Set_pid_0     = set_pid_0_r;
  assign bus.Set_ctx       = set_ctx_r;
  assign bus.id_proc_atual = atual;
  assign bus.pronto        = pronto_r;

`ifdef ESCALONADOR_ESTATISTICA_EN
  logic [15:0] n_pre;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      n_pre <= 16'd0;
    else if (!bus.Sel_BIOS && state == EXECUTANDO && expira && !bus.fim_proc &&
             n_pre != 16'hFFFF)
      n_pre <= n_pre + 16'd1;
  end

  assign bus.n_preempcoes = n_pre;
`endif

endmodule

// File: tb/tb_escalonador_quantum.sv
// Scoreboard bench for escalonador_quantum: a transaction-level model predicts
// each pulse (kind, PID, cycle); a negedge monitor pops and compares.
module tb_escalonador_quantum;
  localparam int QW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  escalonador_quantum_if #(.QW(QW)) bus();
  escalonador_quantum #(.QW(QW), .QUANTUM_INI(8'd16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { bit is_ctx; logic [1:0] pid; int cyc; } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: abstract phase plus ready set, rotation pointer, budgets.
  localparam int P_IDLE = 0, P_DISP = 1, P_RUN = 2, P_PRE = 3, P_WAIT = 4;
  int          m_phase;
  bit          m_ok;
  logic [3:0]  m_mask;
  logic [7:0]  m_q, m_qa;
  int          m_cnt;
  logic [1:0]  m_last, m_cur;
  int unsigned m_npre;

  function automatic logic [1:0] pick();
    for (int off = 1; off <= 3; off++) begin
      int p;
      p = ((int'(m_last) - 1 + off) % 3) + 1;
      if (m_mask[p]) return 2'(p);
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_ok = 0; m_mask = 4'd0; m_q = 8'd16; m_qa = 8'd16;
    m_cnt = 0; m_last = 2'd3; m_cur = 2'd0; m_npre = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [3:0] mask_n;
    logic [7:0] q_n;
    logic [1:0] p;
    bit counts, expire, fim;
    ev_t e;
    mask_n = bus.pronto_wr ? (bus.pronto_din & 4'b1110) : m_mask;
    q_n    = bus.quantum_wr ? bus.quantum_din : m_q;
    counts = bus.instr_valida && bus.id_proc != 2'd0;
    fim    = bus.fim_proc;
    if (bus.Sel_BIOS) begin
      m_phase = P_IDLE; m_cnt = 0;
    end else if ((m_phase == P_IDLE || m_phase == P_WAIT) && bus.ack_so) begin
      p = pick();
      m_phase = P_DISP;
      m_ok = (p != 2'd0);
      if (m_ok) begin
        m_cur = p; m_last = p; m_cnt = 0; m_qa = m_q;
        e.is_ctx = 1; e.pid = p; e.cyc = cyc; exp_q.push_back(e);
      end
    end else if (m_phase == P_DISP) begin
      m_phase = m_ok ? P_RUN : P_IDLE;
    end else if (m_phase == P_RUN) begin
      expire = counts && m_qa != 0 && (m_cnt + 1 == int'(m_qa));
      if (counts && m_cnt < 255) m_cnt++;
      if (fim) mask_n[m_cur] = 1'b0;
      if (expire || fim) begin
        m_phase = P_PRE; m_cnt = 0;
        e.is_ctx = 0; e.pid = 2'd0; e.cyc = cyc; exp_q.push_back(e);
        if (expire && !fim && m_npre < 65535) m_npre++;
      end
    end else if (m_phase == P_PRE) begin
      m_phase = P_WAIT;
    end
    m_mask = mask_n;
    m_q = q_n;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!reset) model_reset();
    else model_step();
  end

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      ev_t ev;
      checks++;
      if (bus.Set_ctx && bus.Set_pid_0) begin
        errors++; $display("FAIL both_pulses cyc=%0d got both high, need at most one", cyc);
      end
      if (bus.Set_ctx || bus.Set_pid_0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d got ctx=%0b pid0=%0b, need none", cyc, bus.Set_ctx, bus.Set_pid_0);
        end else begin
          ev = exp_q.pop_front();
          if (ev.is_ctx != bus.Set_ctx || ev.cyc != cyc ||
              (ev.is_ctx && ev.pid != bus.id_proc_atual)) begin
            errors++;
            $display("FAIL pulse cyc=%0d got ctx=%0b pid=%0d, need ctx=%0b pid=%0d at cyc=%0d",
                     cyc, bus.Set_ctx, bus.id_proc_atual, ev.is_ctx, ev.pid, ev.cyc);
          end
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missing_pulse got none, need ctx=%0b pid=%0d at cyc=%0d",
                 exp_q[0].is_ctx, exp_q[0].pid, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      checks++;
      if (bus.pronto !== m_mask) begin
        errors++; $display("FAIL pronto cyc=%0d got %b need %b", cyc, bus.pronto, m_mask);
      end
      checks++;
      if (bus.id_proc_atual !== m_cur) begin
        errors++; $display("FAIL id_proc_atual cyc=%0d got %0d need %0d", cyc, bus.id_proc_atual, m_cur);
      end
`ifdef ESCALONADOR_ESTATISTICA_EN
      checks++;
      if (bus.n_preempcoes !== 16'(m_npre)) begin
        errors++; $display("FAIL n_preempcoes cyc=%0d got %0d need %0d", cyc, bus.n_preempcoes, m_npre);
      end
`endif
    end
  end

  task automatic expect_val(input string name, input logic [7:0] got, input logic [7:0] need);
    checks++;
    if (got !== need) begin
      errors++; $display("FAIL %s got %0h need %0h", name, got, need);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    expect_val({tag, "_Set_pid_0"}, 8'(bus.Set_pid_0), 8'd0);
    expect_val({tag, "_Set_ctx"}, 8'(bus.Set_ctx), 8'd0);
    expect_val({tag, "_id_proc_atual"}, 8'(bus.id_proc_atual), 8'd0);
    expect_val({tag, "_pronto"}, 8'(bus.pronto), 8'd0);
  endtask

  // Advance one cycle, then drop all single-cycle strobes.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      bus.instr_valida = 0; bus.fim_proc = 0; bus.ack_so = 0;
      bus.quantum_wr = 0; bus.pronto_wr = 0;
    end
  endtask

  task automatic run_instr(input logic [1:0] pid, input int n);
    repeat (n) begin
      bus.id_proc = pid; bus.instr_valida = 1; tick();
    end
    bus.id_proc = 2'd0;
  endtask

  initial begin
    bus.Sel_BIOS = 0; bus.id_proc = 0; bus.instr_valida = 0; bus.fim_proc = 0;
    bus.ack_so = 0; bus.quantum_wr = 0; bus.quantum_din = 0;
    bus.pronto_wr = 0; bus.pronto_din = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1;
    tick();

    // Bit 0 of the ready mask is always stored as 0.
    bus.pronto_wr = 1; bus.pronto_din = 4'b0111; tick();
    expect_val("pronto_bit0", 8'(bus.pronto), 8'h06);
    bus.quantum_wr = 1; bus.quantum_din = 8'd4; tick();
    bus.ack_so = 1; tick();
    expect_val("first_dispatch", 8'(bus.id_proc_atual), 8'd1);
    tick();
    run_instr(2'd1, 4);
    tick(2);
    bus.ack_so = 1; tick(2);
    expect_val("second_dispatch", 8'(bus.id_proc_atual), 8'd2);
    run_instr(2'd2, 4);
    tick(2);

    // HALT coinciding with expiry, only PID 1 ready.
    bus.pronto_wr = 1; bus.pronto_din = 4'b0010; tick();
    bus.ack_so = 1; tick(2);
    run_instr(2'd1, 3);
    bus.id_proc = 2'd1; bus.instr_valida = 1; bus.fim_proc = 1; tick();
    bus.id_proc = 2'd0; tick(2);
    expect_val("halt_clears", 8'(bus.pronto), 8'h00);
    bus.ack_so = 1; tick(3);

    // Quantum rewrite mid-run applies at the next dispatch.
    bus.pronto_wr = 1; bus.pronto_din = 4'b0110; tick();
    bus.quantum_wr = 1; bus.quantum_din = 8'd5; tick();
    bus.ack_so = 1; tick(2);
    run_instr(2'd2, 1);
    bus.quantum_wr = 1; bus.quantum_din = 8'd2; tick();
    run_instr(2'd2, 4);
    tick(2);
    bus.ack_so = 1; tick(2);
    run_instr(2'd1, 2);
    tick(3);

    // Randomized traffic; the OS side runs whatever the model says is running.
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        @(negedge clk);
        #2 reset = 0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1;
      end
      bus.Sel_BIOS     = ($urandom_range(0, 59) == 0);
      bus.id_proc      = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) :
                         (m_phase == P_RUN ? m_cur : 2'd0);
      bus.instr_valida = $urandom_range(0, 1);
      bus.fim_proc     = ($urandom_range(0, 24) == 0);
      bus.ack_so       = ($urandom_range(0, 5) == 0);
      bus.pronto_wr    = ($urandom_range(0, 19) == 0);
      bus.pronto_din   = 4'($urandom_range(0, 15));
      bus.quantum_wr   = ($urandom_range(0, 39) == 0);
      bus.quantum_din  = 8'($urandom_range(0, 6));
      tick();
    end
    bus.Sel_BIOS = 0;
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pending_pulses got %0d outstanding, need 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
